// File: rtl/lsu_master_if.sv
// Bus bundle for the load/store unit: the CPU request/response channel and
// the word-organised data memory channel. The master modport is the LSU view;
// the slave modport is the view of the CPU datapath and memory around it.
interface lsu_master_if;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic        cpu_we;
  logic [1:0]  cpu_size;
  logic        cpu_signed;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_resp_valid;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    input  cpu_req_valid, cpu_we, cpu_size, cpu_signed, cpu_addr, cpu_wdata,
           mem_gnt, mem_rvalid, mem_rdata,
    output cpu_req_ready, cpu_resp_valid, cpu_rdata, cpu_err,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output cpu_req_valid, cpu_we, cpu_size, cpu_signed, cpu_addr, cpu_wdata,
           mem_gnt, mem_rvalid, mem_rdata,
    input  cpu_req_ready, cpu_resp_valid, cpu_rdata, cpu_err,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_master.sv
// Load/store initiator. Takes one byte/half/word access from the CPU,
// turns it into word-aligned memory requests (read-modify-write for
// sub-word stores), extracts and extends load data, and aborts with an
// error on illegal addresses/sizes or when memory stops responding.
module lsu_master #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000,
  parameter int unsigned TIMEOUT    = 16
) (
  input logic          clk,
  input logic          reset,
  lsu_master_if.master bus
);

  localparam int unsigned   CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO     = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [1:0]    SZ_BYTE = 2'b00;
  localparam logic [1:0]    SZ_HALF = 2'b01;
  localparam logic [1:0]    SZ_WORD = 2'b10;

  // MERGE is a one-cycle internal step that builds the write word from the
  // captured read data, keeping the merge logic off the rvalid input path.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_MERGE   = 3'd3,
    S_WR_REQ  = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  state_t        state_q;
  logic          we_q;
  logic          sgn_q;
  logic [1:0]    size_q;
  logic [1:0]    off_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rword_q;
  logic [CW-1:0] cnt_q;

  logic          ready_q;
  logic          resp_valid_q;
  logic          err_q;
  logic [31:0]   rdata_q;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [31:0]   mem_addr_q;
  logic [31:0]   mem_wdata_q;

  logic          misalign_d;
  logic          acc_err_d;
  logic [CW-1:0] cnt_d;
  logic          tmo_d;

  // Select the addressed lane of a word and extend it to 32 bits.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic        sgn,
                                               input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: res = {{24{sgn & b[7]}}, b};
      SZ_HALF: res = {{16{sgn & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace only the addressed lane of a word with the low store bits.
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off);
    logic [31:0] res;
    res = word;
    case (size)
      SZ_BYTE: res[{off, 3'b000} +: 8]    = wdata[7:0];
      SZ_HALF: res[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: res = wdata;
    endcase
    return res;
  endfunction

  // Accept-time legality check and wait-state counter step.
  always_comb begin
    misalign_d = 1'b0;
    case (bus.cpu_size)
      SZ_BYTE: misalign_d = 1'b0;
      SZ_HALF: misalign_d = bus.cpu_addr[0];
      SZ_WORD: misalign_d = (bus.cpu_addr[1:0] != 2'b00);
      default: misalign_d = 1'b1;
    endcase
    acc_err_d = misalign_d || (bus.cpu_addr >= ADDR_LIMIT);
    cnt_d     = cnt_q + CNT_ONE;
    tmo_d     = (cnt_d == TMO);
  end

  // Access sequencing FSM; every bus output is a register set on transitions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      sgn_q        <= 1'b0;
      size_q       <= 2'b00;
      off_q        <= 2'b00;
      wdata_q      <= 32'h0000_0000;
      rword_q      <= 32'h0000_0000;
      cnt_q        <= '0;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= 32'h0000_0000;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0000_0000;
      mem_wdata_q  <= 32'h0000_0000;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (bus.cpu_req_valid && ready_q) begin
            ready_q    <= 1'b0;
            we_q       <= bus.cpu_we;
            sgn_q      <= bus.cpu_signed;
            size_q     <= bus.cpu_size;
            off_q      <= bus.cpu_addr[1:0];
            wdata_q    <= bus.cpu_wdata;
            mem_addr_q <= {bus.cpu_addr[31:2], 2'b00};
            cnt_q      <= '0;
            if (acc_err_d) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              err_q        <= 1'b1;
              rdata_q      <= 32'h0000_0000;
            end else if (bus.cpu_we && (bus.cpu_size == SZ_WORD)) begin
              state_q     <= S_WR_REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= 1'b1;
              mem_wdata_q <= bus.cpu_wdata;
            end else begin
              state_q   <= S_RD_REQ;
              mem_req_q <= 1'b1;
              mem_we_q  <= 1'b0;
            end
          end
        end
        S_RD_REQ: begin
          // rvalid is deliberately not looked at here: it must follow gnt.
          if (bus.mem_gnt) begin
            state_q   <= S_RD_WAIT;
            mem_req_q <= 1'b0;
            cnt_q     <= '0;
          end else if (tmo_d) begin
            state_q      <= S_RESP;
            mem_req_q    <= 1'b0;
            resp_valid_q <= 1'b1;
            err_q        <= 1'b1;
            rdata_q      <= 32'h0000_0000;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_RD_WAIT: begin
          if (bus.mem_rvalid) begin
            rword_q <= bus.mem_rdata;
            cnt_q   <= '0;
            if (!we_q) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              err_q        <= 1'b0;
              rdata_q      <= lane_extract(bus.mem_rdata, size_q, sgn_q, off_q);
            end else begin
              state_q <= S_MERGE;
            end
          end else if (tmo_d) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            err_q        <= 1'b1;
            rdata_q      <= 32'h0000_0000;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_MERGE: begin
          state_q     <= S_WR_REQ;
          mem_req_q   <= 1'b1;
          mem_we_q    <= 1'b1;
          mem_wdata_q <= lane_merge(rword_q, wdata_q, size_q, off_q);
          cnt_q       <= '0;
        end
        S_WR_REQ: begin
          if (bus.mem_gnt) begin
            state_q      <= S_RESP;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            err_q        <= 1'b0;
            rdata_q      <= 32'h0000_0000;
          end else if (tmo_d) begin
            state_q      <= S_RESP;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            err_q        <= 1'b1;
            rdata_q      <= 32'h0000_0000;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          err_q   <= 1'b0;
          rdata_q <= 32'h0000_0000;
        end
        default: begin
          state_q   <= S_IDLE;
          ready_q   <= 1'b0;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_req_ready  = ready_q;
  assign bus.cpu_resp_valid = resp_valid_q;
  assign bus.cpu_rdata      = rdata_q;
  assign bus.cpu_err        = err_q;
  assign bus.mem_req        = mem_req_q;
  assign bus.mem_we         = mem_we_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_wdata      = mem_wdata_q;

endmodule

// File: tb/tb_lsu_master.sv
// Randomized self-checking bench for lsu_master with a word-array memory
// responder and an arithmetic reference model of the access rules.
module tb_lsu_master;
  localparam logic [31:0] LIMIT = 32'h0000_3000;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;

  logic [31:0] mem_q [int];
  logic [31:0] ref_q [int];

  lsu_master_if bus ();

  lsu_master #(.ADDR_LIMIT(LIMIT), .TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] seed_word(input logic [31:0] wa);
    return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] mem_get(input logic [31:0] wa);
    if (mem_q.exists(int'(wa))) return mem_q[int'(wa)];
    return seed_word(wa);
  endfunction

  function automatic logic [31:0] ref_get(input logic [31:0] wa);
    if (ref_q.exists(int'(wa))) return ref_q[int'(wa)];
    return seed_word(wa);
  endfunction

  function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && a[0]) return 1'b1;
    if (sz == 2'd2 && a[1:0] != 2'd0) return 1'b1;
    return (a >= LIMIT);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic sgn, input logic [31:0] a);
    int unsigned sh;
    logic [31:0] v;
    if (sz == 2'd2) return w;
    if (sz == 2'd0) begin
      sh = 8 * int'(a[1:0]);
      v  = (w >> sh) & 32'h0000_00FF;
      if (sgn && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else begin
      sh = 16 * int'(a[1]);
      v  = (w >> sh) & 32'h0000_FFFF;
      if (sgn && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] w, input logic [31:0] wd,
                                            input logic [1:0] sz, input logic [31:0] a);
    int unsigned sh;
    logic [31:0] mask;
    sh   = (sz == 2'd0) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
    mask = ((sz == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    return (w & ~mask) | ((wd << sh) & mask);
  endfunction

  // One CPU access with a cycle-by-cycle memory responder. gnt_dly: extra
  // request cycles before gnt; rv_dly (>=1): cycles from gnt to rvalid.
  task automatic run_access(input string tag, input logic we, input logic [1:0] sz,
                            input logic sgn, input logic [31:0] a, input logic [31:0] wd,
                            input int gnt_dly, input int rv_dly, input logic rv_never,
                            input logic junk_rv, input logic tmo_exp);
    logic [31:0] wa, exp_rdata, exp_wdata, got_rdata, got_wdata, rd_addr;
    logic exp_err, exp_wr, got_err, accepted, done;
    int cyc, acc_cyc, resp_cyc, gcnt, rv_wait, wr_cnt, req_cyc, exp_lat;

    wa        = {a[31:2], 2'b00};
    exp_err   = ref_err(sz, a) | tmo_exp;
    exp_wr    = !exp_err && we;
    exp_rdata = (exp_err || we) ? 32'h0 : ref_load(ref_get(wa), sz, sgn, a);
    exp_wdata = (sz == 2'd2) ? wd : ref_merge(ref_get(wa), wd, sz, a);
    if (ref_err(sz, a))   exp_lat = 1;
    else if (!we)         exp_lat = 3 + gnt_dly + rv_dly - 1;
    else if (sz == 2'd2)  exp_lat = 2 + gnt_dly;
    else                  exp_lat = 5 + 2 * gnt_dly + rv_dly - 1;

    got_rdata = 32'h0; got_wdata = 32'h0; got_err = 1'b0; rd_addr = 32'h0;
    accepted = 1'b0; done = 1'b0;
    cyc = 0; acc_cyc = 0; resp_cyc = 0; gcnt = 0; rv_wait = 0; wr_cnt = 0; req_cyc = 0;

    @(negedge clk);
    bus.cpu_we = we; bus.cpu_size = sz; bus.cpu_signed = sgn;
    bus.cpu_addr = a; bus.cpu_wdata = wd; bus.cpu_req_valid = 1'b1;
    while (!done && cyc < 300) begin
      bus.mem_gnt = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata = $urandom;
      if (accepted) bus.cpu_req_valid = 1'b0;
      else if (bus.cpu_req_ready) begin accepted = 1'b1; acc_cyc = cyc; end
      if (bus.cpu_resp_valid) begin
        done = 1'b1; resp_cyc = cyc; got_rdata = bus.cpu_rdata; got_err = bus.cpu_err;
      end
      if (rv_wait > 0) begin
        rv_wait--;
        if (rv_wait == 0 && !rv_never) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = mem_get(rd_addr);
        end
      end
      if (bus.mem_req) begin
        req_cyc++;
        if (gcnt >= gnt_dly) begin
          gcnt = 0;
          bus.mem_gnt = 1'b1;
          check_eq({tag, ".addr"}, bus.mem_addr, wa);
          if (bus.mem_we) begin
            wr_cnt++;
            got_wdata = bus.mem_wdata;
            mem_q[int'(bus.mem_addr)] = bus.mem_wdata;
          end else begin
            rd_addr = bus.mem_addr;
            rv_wait = rv_dly;
            if (junk_rv) begin
              bus.mem_rvalid = 1'b1;
              bus.mem_rdata  = ~mem_get(bus.mem_addr);
            end
          end
        end else begin
          gcnt++;
        end
      end else begin
        gcnt = 0;
      end
      cyc++;
      @(negedge clk);
    end
    bus.cpu_req_valid = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;

    check_eq({tag, ".resp"}, 32'(done), 32'd1);
    check_eq({tag, ".rdata"}, got_rdata, exp_rdata);
    check_eq({tag, ".err"}, 32'(got_err), 32'(exp_err));
    if (!tmo_exp) check_eq({tag, ".lat"}, 32'(resp_cyc - acc_cyc), 32'(exp_lat));
    check_eq({tag, ".nwr"}, 32'(wr_cnt), exp_wr ? 32'd1 : 32'd0);
    if (exp_wr) check_eq({tag, ".wdata"}, got_wdata, exp_wdata);
    if (ref_err(sz, a)) check_eq({tag, ".noreq"}, 32'(req_cyc), 32'd0);
    check_eq({tag, ".pulse"}, 32'(bus.cpu_resp_valid), 32'd0);
    check_eq({tag, ".ready"}, 32'(bus.cpu_req_ready), 32'd1);
    if (exp_wr) ref_q[int'(wa)] = exp_wdata;
  endtask

  int n_req;
  int n_rsp;

  // Directed scenarios, reset-in-flight, then randomized traffic
  initial begin
    clk = 1'b0; reset = 1'b1; n_vec = 0; n_bad = 0;
    bus.cpu_req_valid = 1'b0; bus.cpu_we = 1'b0; bus.cpu_size = 2'b00; bus.cpu_signed = 1'b0;
    bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    #2 reset = 1'b0;
    #3;
    check_eq("rst.ready", 32'(bus.cpu_req_ready), 32'd0);
    check_eq("rst.req", {30'd0, bus.mem_req, bus.mem_we}, 32'd0);
    check_eq("rst.resp", {30'd0, bus.cpu_resp_valid, bus.cpu_err}, 32'd0);
    check_eq("rst.rdata", bus.cpu_rdata, 32'h0);
    check_eq("rst.maddr", bus.mem_addr, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    mem_q[32'h20] = 32'h80FF_7F01; ref_q[32'h20] = 32'h80FF_7F01;
    mem_q[32'h40] = 32'h1122_3344; ref_q[32'h40] = 32'h1122_3344;

    run_access("sw10",  1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, 1, 1'b0, 1'b0, 1'b0);
    run_access("lw10",  1'b0, 2'd2, 1'b0, 32'h10, 32'h0,         0, 1, 1'b0, 1'b0, 1'b0);
    check_eq("lw10.model", ref_get(32'h10), 32'hDEAD_BEEF);
    run_access("lb23",  1'b0, 2'd0, 1'b1, 32'h23, 32'h0, 0, 1, 1'b0, 1'b0, 1'b0);
    run_access("lbu22", 1'b0, 2'd0, 1'b0, 32'h22, 32'h0, 0, 1, 1'b0, 1'b0, 1'b0);
    run_access("lb21",  1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 0, 1, 1'b0, 1'b0, 1'b0);
    run_access("sh42",  1'b1, 2'd1, 1'b0, 32'h42, 32'hAAAA_5555, 0, 1, 1'b0, 1'b0, 1'b0);
    run_access("sb41",  1'b1, 2'd0, 1'b0, 32'h41, 32'h0000_009C, 0, 1, 1'b0, 1'b0, 1'b0);
    check_eq("sb41.mem", mem_get(32'h40), 32'h5555_9C44);
    run_access("e.lw6",  1'b0, 2'd2, 1'b0, 32'h6,    32'h0, 0, 1, 1'b0, 1'b0, 1'b0);
    run_access("e.sh3",  1'b1, 2'd1, 1'b0, 32'h3,    32'h1234, 0, 1, 1'b0, 1'b0, 1'b0);
    run_access("e.sw3k", 1'b1, 2'd2, 1'b0, 32'h3000, 32'h1, 0, 1, 1'b0, 1'b0, 1'b0);
    run_access("e.sz3",  1'b0, 2'd3, 1'b0, 32'h20,   32'h0, 0, 1, 1'b0, 1'b0, 1'b0);
    run_access("e.lim",  1'b0, 2'd0, 1'b0, 32'h2FFF, 32'h0, 0, 1, 1'b0, 1'b0, 1'b0);
    run_access("stl.lw", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 5, 7, 1'b0, 1'b0, 1'b0);
    run_access("stl.sb", 1'b1, 2'd0, 1'b0, 32'h23, 32'h0000_0066, 5, 7, 1'b0, 1'b0, 1'b0);
    run_access("junkrv", 1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 0, 2, 1'b0, 1'b1, 1'b0);
    run_access("to.rv",  1'b1, 2'd0, 1'b0, 32'h48, 32'h77, 0, 1, 1'b1, 1'b0, 1'b1);
    run_access("to.rg",  1'b0, 2'd2, 1'b0, 32'h4C, 32'h0, 1000, 1, 1'b0, 1'b0, 1'b1);
    run_access("to.wg",  1'b1, 2'd2, 1'b0, 32'h4C, 32'h5, 1000, 1, 1'b0, 1'b0, 1'b1);

    // Reset while a sub-word store waits for read data
    @(negedge clk);
    bus.cpu_we = 1'b1; bus.cpu_size = 2'd0; bus.cpu_signed = 1'b0;
    bus.cpu_addr = 32'h44; bus.cpu_wdata = 32'hAB; bus.cpu_req_valid = 1'b1;
    @(negedge clk);
    bus.cpu_req_valid = 1'b0;
    check_eq("rmid.req", 32'(bus.mem_req), 32'd1);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_eq("rmid.mreq", {30'd0, bus.mem_req, bus.mem_we}, 32'd0);
    check_eq("rmid.resp", {29'd0, bus.cpu_resp_valid, bus.cpu_err, bus.cpu_req_ready}, 32'd0);
    check_eq("rmid.data", bus.cpu_rdata | bus.mem_addr | bus.mem_wdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678;
    n_req = 0; n_rsp = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      if (bus.mem_req) n_req++;
      if (bus.cpu_resp_valid) n_rsp++;
    end
    check_eq("rpost.req", 32'(n_req), 32'd0);
    check_eq("rpost.resp", 32'(n_rsp), 32'd0);
    check_eq("rpost.ready", 32'(bus.cpu_req_ready), 32'd1);

    for (int i = 0; i < 200; i++) begin
      logic        r_we, r_sgn, r_junk;
      logic [1:0]  r_sz;
      logic [31:0] r_a;
      int          r_k;
      r_we   = 1'($urandom_range(0, 1));
      r_sgn  = 1'($urandom_range(0, 1));
      r_junk = 1'($urandom_range(0, 1));
      r_k    = int'($urandom_range(0, 7));
      r_sz   = (r_k < 3) ? 2'd0 : (r_k < 5) ? 2'd1 : (r_k < 7) ? 2'd2 : 2'd3;
      if ($urandom_range(0, 9) == 0) r_a = LIMIT + 32'($urandom_range(0, 64));
      else r_a = 32'h100 + 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
      run_access("rnd", r_we, r_sz, r_sgn, r_a, $urandom,
                 int'($urandom_range(0, 4)), int'($urandom_range(1, 6)), 1'b0, r_junk, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/lsu_master.md
Name: lsu_master

Overview:
- Load/store initiator between the CPU datapath and the word-organised data memory.
- Accepts one byte, halfword or word access at a time from the CPU over a valid/ready handshake.
- Issues word-aligned requests to memory over a req/gnt/rvalid handshake.
- Performs sub-word extraction with sign or zero extension on loads. Because memory writes whole words only, sub-word stores are done as read-modify-write.

Parameters:
- ADDR_LIMIT, 32'h0000_3000, first byte address outside data memory; any access at or above it is an error.
- TIMEOUT, 16, maximum cycles spent waiting for mem_gnt or mem_rvalid before the access is aborted with error.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req_valid  in  1  CPU access request.
- cpu_req_ready  out  1  high only in IDLE; request accepted when valid&&ready.
- cpu_we  in  1  1=store, 0=load.
- cpu_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as error).
- cpu_signed  in  1  load extension: 1=sign, 0=zero.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data; sub-word data is taken from the low bits.
- cpu_resp_valid  out  1  one-cycle completion pulse; no backpressure.
- cpu_rdata  out  32  load result, valid with cpu_resp_valid; 0 for stores and errors.
- cpu_err  out  1  valid with cpu_resp_valid.
- mem_req  out  1  memory request, held until granted.
- mem_we  out  1  write request.
- mem_addr  out  32  word address, {cpu_addr[31:2],2'b00}.
- mem_wdata  out  32  full write word.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid; arrives at least 1 cycle after the read gnt.
- mem_rdata  in  32  read data.

Behaviour:
- Reset (asynchronous, active-low) forces state IDLE and clears all outputs and registers to 0. An access in flight is dropped with no response.
- Reset release: a stray mem_rvalid after release is ignored, because rvalid is ignored in every state except RD_WAIT.
- Accept (IDLE, valid&&ready): latch we, size, signed, addr and wdata.
- Error checks at accept:
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - Reserved size 11.
  - addr >= ADDR_LIMIT.
  - Any of these: go to RESP with err=1 and issue no memory access.
- Paths from IDLE:
  - Load: RD_REQ.
  - Word store: WR_REQ.
  - Byte or half store: RD_REQ (read-modify-write).
- RD_REQ: mem_req=1, mem_we=0. On gnt go to RD_WAIT and clear the wait counter.
- RD_WAIT: on rvalid, capture mem_rdata.
  - Load: go to RESP.
  - Sub-word store: merge into the captured word and go to WR_REQ.
- WR_REQ: mem_req=1, mem_we=1, mem_wdata = merged word or cpu_wdata. On gnt go to RESP; the write completes at gnt.
- RESP: cpu_resp_valid=1 for exactly one cycle, then IDLE.
- Minimum latency, counted from the accept cycle: load 3 cycles, word store 2 cycles, sub-word store 5 cycles.
- Byte lanes are little-endian: byte k = word[8k+7:8k]; half selected by addr[1] = word[16*addr[1]+15 -: 16].
- Load result: the selected byte/half extended to 32 bits, sign extended per cpu_signed; a word load returns the word unchanged.
- Merge: replace only the addressed lane with cpu_wdata[7:0] or cpu_wdata[15:0]; all other lanes keep their read value.
- Timeout: the counter increments each cycle in RD_REQ, RD_WAIT and WR_REQ and resets on each state change. On reaching TIMEOUT, drop mem_req and go to RESP with err=1 and rdata=0; no write is issued.
- Simultaneous events:
  - gnt and rvalid in the same cycle while in RD_REQ: rvalid is ignored, because it must follow gnt.
  - cpu_req_valid while busy: not accepted.
- mem_addr and mem_we are stable while mem_req=1.

Test Plan:
- Word store then load: store addr 0x10, data 0xDEADBEEF, gnt immediate; then load word 0x10 with rvalid 1 cycle later -> one mem write of 0xDEADBEEF to 0x10; load response rdata=0xDEADBEEF, err=0, exactly 3 cycles after accept.
- Byte loads: mem word at 0x20 = 0x80FF7F01; lb (signed) at 0x23 -> 0xFFFFFF80; lbu at 0x22 -> 0x000000FF; lb at 0x21 -> 0x0000007F.
- Sub-word store RMW: memory holds 0x11223344 at 0x40; sh 0xAAAA5555 to 0x42 -> read of 0x40, then write of 0x55553344; sb 0x9C to 0x41 -> write of 0x55559C44.
- Errors: lw at 0x6, sh at 0x3, sw at 0x3000 -> each gives resp_valid with err=1 and rdata=0, with mem_req never asserted.
- Handshake stalls: gnt delayed 5 cycles and rvalid delayed 7 cycles -> mem_req held steady and correct data returned; rvalid withheld 16 cycles -> err=1 with no write issued.
- Reset mid-operation: assert reset during RD_WAIT of a sub-word store -> outputs 0 immediately, no write ever issued; a late rvalid after release is ignored and cpu_req_ready=1.
